// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit accumulator CPU: widths, opcodes,
// controller state type and the decoder's operand/destination selectors.
package cpu4_pkg;

  localparam int DATA_W = 4;
  localparam int INST_W = 8;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_JNC    = 4'h0;
  localparam logic [OP_W-1:0] OP_MOV_AI = 4'h1;
  localparam logic [OP_W-1:0] OP_MOV_BI = 4'h2;
  localparam logic [OP_W-1:0] OP_MOV_AB = 4'h3;
  localparam logic [OP_W-1:0] OP_ADD_AI = 4'h4;
  localparam logic [OP_W-1:0] OP_ADD_AB = 4'h5;
  localparam logic [OP_W-1:0] OP_SUB_AI = 4'h6;
  localparam logic [OP_W-1:0] OP_SUB_AB = 4'h7;
  localparam logic [OP_W-1:0] OP_NOT_A  = 4'h8;
  localparam logic [OP_W-1:0] OP_NOT_B  = 4'h9;
  localparam logic [OP_W-1:0] OP_OR_AI  = 4'hA;
  localparam logic [OP_W-1:0] OP_OR_AB  = 4'hB;
  localparam logic [OP_W-1:0] OP_AND_AI = 4'hC;
  localparam logic [OP_W-1:0] OP_AND_AB = 4'hD;
  localparam logic [OP_W-1:0] OP_XOR_AI = 4'hE;
  localparam logic [OP_W-1:0] OP_XOR_AB = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_A    = 2'd1,
    DEST_B    = 2'd2
  } dest_sel_t;

  typedef enum logic [1:0] {
    D1_ZERO = 2'd0,
    D1_IMM  = 2'd1,
    D1_A    = 2'd2,
    D1_B    = 2'd3
  } d1_sel_t;

  typedef enum logic [1:0] {
    D2_ZERO = 2'd0,
    D2_IMM  = 2'd1,
    D2_B    = 2'd2
  } d2_sel_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Purely combinational opcode decoder: tells the controller which
// operands to put on the ALU buses and which register the result lands in.
module cpu_ctrl_decode
  import cpu4_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output dest_sel_t       dest_sel,
  output d1_sel_t         d1_sel,
  output d2_sel_t         d2_sel,
  output logic            uses_alu,
  output logic            is_jnc
);

  // Map each opcode onto operand sources and a destination; unused D2 stays zero.
  always_comb begin
    dest_sel = DEST_NONE;
    d1_sel   = D1_ZERO;
    d2_sel   = D2_ZERO;
    uses_alu = 1'b1;
    is_jnc   = 1'b0;
    case (opcode)
      OP_JNC: begin
        uses_alu = 1'b0;
        is_jnc   = 1'b1;
      end
      OP_MOV_AI: begin
        d1_sel   = D1_IMM;
        dest_sel = DEST_A;
      end
      OP_MOV_BI: begin
        d1_sel   = D1_IMM;
        dest_sel = DEST_B;
      end
      OP_MOV_AB: begin
        d1_sel   = D1_B;
        dest_sel = DEST_A;
      end
      OP_ADD_AI, OP_SUB_AI, OP_OR_AI, OP_AND_AI, OP_XOR_AI: begin
        d1_sel   = D1_A;
        d2_sel   = D2_IMM;
        dest_sel = DEST_A;
      end
      OP_ADD_AB, OP_SUB_AB, OP_OR_AB, OP_AND_AB, OP_XOR_AB: begin
        d1_sel   = D1_A;
        d2_sel   = D2_B;
        dest_sel = DEST_A;
      end
      OP_NOT_A: begin
        d1_sel   = D1_A;
        dest_sel = DEST_A;
      end
      OP_NOT_B: begin
        d1_sel   = D1_B;
        dest_sel = DEST_B;
      end
      default: begin
        uses_alu = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle controller for a 4-bit CPU with an external registered ALU.
// Each instruction runs FETCH -> EXEC -> WB; the ALU result registered at
// the end of EXEC is written back to A/B and FLAG_C during WB.
module cpu_ctrl
  import cpu4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [DATA_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [OP_W-1:0]   alu_inst,
  output logic [DATA_W-1:0] alu_d1,
  output logic [DATA_W-1:0] alu_d2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_c,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic              flag_c,
  output logic              busy
);

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] pc;
  logic [INST_W-1:0] ir;
  logic [OP_W-1:0]   opcode;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] pc_inc;
  logic [DATA_W-1:0] d1_val;
  logic [DATA_W-1:0] d2_val;
  dest_sel_t         dest_sel;
  d1_sel_t           d1_sel;
  d2_sel_t           d2_sel;
  logic              uses_alu;
  logic              is_jnc;

  assign opcode   = ir[INST_W-1:DATA_W];
  assign imm      = ir[DATA_W-1:0];
  assign pc_inc   = pc + 4'd1;
  assign rom_addr = pc;
  assign busy     = (state != ST_IDLE);

  cpu_ctrl_decode u_decode (
    .opcode   (opcode),
    .dest_sel (dest_sel),
    .d1_sel   (d1_sel),
    .d2_sel   (d2_sel),
    .uses_alu (uses_alu),
    .is_jnc   (is_jnc)
  );

  // Operand multiplexers feeding the ALU buses while in EXEC.
  always_comb begin
    d1_val = '0;
    d2_val = '0;
    case (d1_sel)
      D1_IMM:  d1_val = imm;
      D1_A:    d1_val = reg_a;
      D1_B:    d1_val = reg_b;
      default: d1_val = '0;
    endcase
    case (d2_sel)
      D2_IMM:  d2_val = imm;
      D2_B:    d2_val = reg_b;
      default: d2_val = '0;
    endcase
  end

  // Next-state sequencing; ALU buses are only driven during EXEC so the ALU holds otherwise.
  always_comb begin
    next_state = state;
    alu_inst   = '0;
    alu_d1     = '0;
    alu_d2     = '0;
    case (state)
      ST_IDLE: begin
        if (run) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        next_state = ST_WB;
        if (uses_alu) begin
          alu_inst = opcode;
          alu_d1   = d1_val;
          alu_d2   = d2_val;
        end
      end
      ST_WB: begin
        next_state = run ? ST_FETCH : ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Architectural state: IR captured in FETCH, results and PC committed in WB; reset wins over the write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= '0;
      ir     <= '0;
      reg_a  <= '0;
      reg_b  <= '0;
      flag_c <= 1'b0;
    end else begin
      if (state == ST_FETCH) begin
        ir <= rom_data;
      end
      if (state == ST_WB) begin
        if (is_jnc) begin
          pc <= flag_c ? pc_inc : imm;
        end else begin
          case (dest_sel)
            DEST_A:  reg_a <= alu_out;
            DEST_B:  reg_b <= alu_out;
            default: ;
          endcase
          flag_c <= alu_c;
          pc     <= pc_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: a bench-side ROM and registered ALU surround
// the controller; an instruction-level reference model predicts each step.
module tb_cpu_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] alu_inst;
  logic [3:0] alu_d1;
  logic [3:0] alu_d2;
  logic [3:0] alu_out;
  logic       alu_c;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic       flag_c;
  logic       busy;

  logic [7:0] rom [16];

  typedef struct {
    int inst;
    int d1;
    int d2;
    int a;
    int b;
    int c;
    int pc;
  } exp_t;

  exp_t sb[$];

  int  n_checks;
  int  n_fail;
  bit  mon_en;
  int  m_pc;
  int  m_a;
  int  m_b;
  int  m_c;

  cpu_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .alu_inst (alu_inst),
    .alu_d1   (alu_d1),
    .alu_d2   (alu_d2),
    .alu_out  (alu_out),
    .alu_c    (alu_c),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .flag_c   (flag_c),
    .busy     (busy)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench ALU: ops on a 4-bit datapath, carry for ADD, borrow for SUB, zero otherwise.
  function automatic logic [4:0] alu_f(input logic [3:0] op, input logic [3:0] d1, input logic [3:0] d2);
    logic [4:0] r;
    r = 5'd0;
    case (op)
      4'h1, 4'h2, 4'h3: r = {1'b0, d1};
      4'h4, 4'h5:       r = {1'b0, d1} + {1'b0, d2};
      4'h6, 4'h7:       r = {(d1 < d2), d1 - d2};
      4'h8, 4'h9:       r = {1'b0, ~d1};
      4'hA, 4'hB:       r = {1'b0, d1 | d2};
      4'hC, 4'hD:       r = {1'b0, d1 & d2};
      4'hE, 4'hF:       r = {1'b0, d1 ^ d2};
      default:          r = 5'd0;
    endcase
    return r;
  endfunction

  // Registered ALU that holds its outputs whenever it sees opcode 0.
  initial begin
    alu_out = 4'd0;
    alu_c   = 1'b0;
  end
  always @(posedge clk) begin
    if (alu_inst != 4'd0) {alu_c, alu_out} <= alu_f(alu_inst, alu_d1, alu_d2);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: executes one instruction at ROM[m_pc] and queues the expected bus values and result.
  task automatic model_step();
    exp_t e;
    int   op;
    int   imm;
    int   s;
    op  = int'(rom[m_pc][7:4]);
    imm = int'(rom[m_pc][3:0]);
    e.inst = op;
    e.d1   = 0;
    e.d2   = 0;
    case (op)
      0: ;
      1: begin e.d1 = imm; m_a = imm; m_c = 0; end
      2: begin e.d1 = imm; m_b = imm; m_c = 0; end
      3: begin e.d1 = m_b; m_a = m_b; m_c = 0; end
      4, 5: begin
        e.d1 = m_a; e.d2 = (op == 4) ? imm : m_b;
        s = m_a + e.d2; m_a = s % 16; m_c = (s > 15) ? 1 : 0;
      end
      6, 7: begin
        e.d1 = m_a; e.d2 = (op == 6) ? imm : m_b;
        m_c = (m_a < e.d2) ? 1 : 0; m_a = (m_a - e.d2 + 16) % 16;
      end
      8: begin e.d1 = m_a; m_a = 15 - m_a; m_c = 0; end
      9: begin e.d1 = m_b; m_b = 15 - m_b; m_c = 0; end
      10, 11: begin e.d1 = m_a; e.d2 = (op == 10) ? imm : m_b; m_a = m_a | e.d2; m_c = 0; end
      12, 13: begin e.d1 = m_a; e.d2 = (op == 12) ? imm : m_b; m_a = m_a & e.d2; m_c = 0; end
      default: begin e.d1 = m_a; e.d2 = (op == 14) ? imm : m_b; m_a = m_a ^ e.d2; m_c = 0; end
    endcase
    if (op == 0) m_pc = (m_c != 0) ? (m_pc + 1) % 16 : imm;
    else         m_pc = (m_pc + 1) % 16;
    e.a = m_a; e.b = m_b; e.c = m_c; e.pc = m_pc;
    sb.push_back(e);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0;
    chk("rst_busy", busy, 0);
    chk("rst_pc", rom_addr, 0);
    chk("rst_a", reg_a, 0);
    chk("rst_b", reg_b, 0);
    chk("rst_c", flag_c, 0);
    chk("rst_alu_inst", alu_inst, 0);
  endtask

  // Run exactly k instructions: RUN held high until the last one is fetched, then dropped.
  task automatic applyStimulus(input int k);
    int t;
    for (int i = 0; i < k; i++) model_step();
    run = 1'b1;
    repeat (3 * k - 2) @(negedge clk);
    run = 1'b0;
    t = 0;
    while (busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pc"}, rom_addr, m_pc);
    chk({tag, "_a"}, reg_a, m_a);
    chk({tag, "_b"}, reg_b, m_b);
    chk({tag, "_c"}, flag_c, m_c);
    repeat (3) @(negedge clk);
    chk({tag, "_pc_hold"}, rom_addr, m_pc);
    chk({tag, "_still_idle"}, busy, 0);
  endtask

  // Monitor: tracks the 3-cycle instruction rhythm, checks ALU buses in EXEC and results after WB.
  initial begin
    int   phase;
    bit   pend;
    bit   have;
    exp_t cur;
    phase = 0;
    pend  = 1'b0;
    have  = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        phase = 0;
        pend  = 1'b0;
      end else begin
        if (pend) begin
          chk("wb_a", reg_a, cur.a);
          chk("wb_b", reg_b, cur.b);
          chk("wb_c", flag_c, cur.c);
          chk("wb_pc", rom_addr, cur.pc);
          pend = 1'b0;
        end
        if (!busy) begin
          phase = 0;
        end else begin
          phase = (phase == 3) ? 1 : phase + 1;
          if (phase == 1) chk("fetch_alu_inst", alu_inst, 0);
          if (phase == 2) begin
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              have = 1'b0;
              $display("[TB] FAIL sb_underflow: got an instruction, expected none");
            end else begin
              cur  = sb.pop_front();
              have = 1'b1;
              chk("exec_alu_inst", alu_inst, cur.inst);
              chk("exec_alu_d1", alu_d1, cur.d1);
              chk("exec_alu_d2", alu_d2, cur.d2);
            end
          end
          if (phase == 3) begin
            pend = have;
            have = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b1;
    rst_n    = 1'b0;
    run      = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    @(negedge clk);

    // ADD from immediate loads
    resetDut();
    rom[0] = 8'h15; rom[1] = 8'h43;
    applyStimulus(2);
    checkOutput("add");
    chk("add_a_eq8", reg_a, 8);
    chk("add_c_eq0", flag_c, 0);
    chk("add_pc_eq2", rom_addr, 2);

    // carry set, JNC falls through
    resetDut();
    rom[0] = 8'h1F; rom[1] = 8'h41; rom[2] = 8'h07;
    applyStimulus(3);
    checkOutput("jnc_nt");
    chk("jnc_nt_a", reg_a, 0);
    chk("jnc_nt_c", flag_c, 1);
    chk("jnc_nt_pc", rom_addr, 3);

    // carry clear, JNC taken
    resetDut();
    rom[1] = 8'h40;
    applyStimulus(3);
    checkOutput("jnc_t");
    chk("jnc_t_c", flag_c, 0);
    chk("jnc_t_pc", rom_addr, 7);

    // MOV B, MOV A,B, SUB borrow
    resetDut();
    rom[0] = 8'h29; rom[1] = 8'h30; rom[2] = 8'h6A;
    applyStimulus(3);
    checkOutput("sub");
    chk("sub_b", reg_b, 9);
    chk("sub_a", reg_a, 15);
    chk("sub_c", flag_c, 1);

    // PC wraps from 15 to 0
    resetDut();
    rom[0] = 8'h0F; rom[15] = 8'h12;
    applyStimulus(2);
    checkOutput("wrap");
    chk("wrap_pc", rom_addr, 0);

    // reset during WB discards the pending write
    mon_en = 1'b0;
    resetDut();
    rom[0] = 8'h1C;
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("wbrst_busy_before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("wbrst_a", reg_a, 0);
    chk("wbrst_pc", rom_addr, 0);
    chk("wbrst_busy", busy, 0);
    chk("wbrst_alu_inst", alu_inst, 0);
    run   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    sb.delete();
    mon_en = 1'b1;

    // random programs, some continuing from the previous state
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      if (p % 3 == 0) resetDut();
      applyStimulus($urandom_range(1, 12));
      checkOutput("rand");
    end

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL sb_leftover: got %0d queued, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
